// File: rtl/vx_tcu_drl_max_exp_pkg.sv
// Shared types and constants for the TCU DRL max-exponent stage.
// Defines the term geometry, the S1 beat layout and the per-term shift rule.
package vx_tcu_drl_max_exp_pkg;

  localparam int TCU_N             = 2;
  localparam int TCU_TCK           = 2 * TCU_N;
  localparam int TCU_TERMS         = TCU_TCK + 1;
  localparam int TCU_DRL_EXP_W     = 10;
  localparam int TCU_DRL_SHIFT_W   = 6;
  localparam int TCU_DRL_SHIFT_MAX = 31;
  localparam int TCU_DRL_TAG_W     = 8;
  localparam int TCU_DRL_DIFF_W    = 6;

  typedef logic [TCU_DRL_EXP_W-1:0]   tcu_drl_exp_t;
  typedef logic [TCU_DRL_SHIFT_W-1:0] tcu_drl_shift_t;

  typedef struct packed {
    logic [TCU_TCK:0][TCU_DRL_EXP_W-1:0]    exp;
    logic [TCU_TCK-1:0][TCU_DRL_DIFF_W-1:0] diff_f8;
    logic [TCU_DRL_TAG_W-1:0]               tag;
  } tcu_drl_exp_beat_t;

  // Difference is taken at full exponent width so large gaps saturate instead
  // of wrapping through the narrow shift field; zero exponents are masked terms.
  function automatic tcu_drl_shift_t drl_shift(input tcu_drl_exp_t max_exp,
                                               input tcu_drl_exp_t exp);
    tcu_drl_exp_t d;
    d = max_exp - exp;
    if (exp == '0 || d > TCU_DRL_EXP_W'(TCU_DRL_SHIFT_MAX))
      return TCU_DRL_SHIFT_W'(TCU_DRL_SHIFT_MAX);
    return d[TCU_DRL_SHIFT_W-1:0];
  endfunction

endpackage

// File: rtl/vx_tcu_drl_max_exp_max_tree.sv
// Combinational unsigned maximum over N_IN values using a balanced pairwise tree.
// An odd leftover entry at any level is promoted unchanged to the next level.
module vx_tcu_drl_max_exp_max_tree #(
  parameter int N_IN = 5,
  parameter int W    = 10
) (
  input  logic [N_IN-1:0][W-1:0] in_vals,
  output logic [W-1:0]           max_val
);

  localparam int LEVELS = (N_IN > 1) ? $clog2(N_IN) : 0;

  // One spare slot per level keeps the 2*j+1 operand index in range.
  logic [W-1:0] lvl [LEVELS+1][N_IN+1];

  always_comb begin
    int cnt;
    // NOTE: every element gets a default before the tree is built, so no path
    // leaves a bit unassigned and no latch is inferred.
    for (int l = 0; l <= LEVELS; l++)
      for (int j = 0; j <= N_IN; j++)
        lvl[l][j] = '0;
    for (int j = 0; j < N_IN; j++)
      lvl[0][j] = in_vals[j];

    cnt = N_IN;
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = 0; j < (N_IN + 1) / 2; j++) begin
        if (2 * j + 1 < cnt)
          lvl[l+1][j] = (lvl[l][2*j] > lvl[l][2*j+1]) ? lvl[l][2*j] : lvl[l][2*j+1];
        else if (2 * j < cnt)
          lvl[l+1][j] = lvl[l][2*j];
      end
      cnt = (cnt + 1) / 2;
    end

    max_val = lvl[LEVELS][0];
  end

endmodule

// File: rtl/vx_tcu_drl_max_exp.sv
// TCU DRL max-exponent stage: 2-stage elastic pipe finding the max biased exponent
// and producing per-term alignment shifts, with FP8 diff and tag carried alongside.
module vx_tcu_drl_max_exp
  import vx_tcu_drl_max_exp_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    valid_in,
  output logic                                    ready_in,
  input  logic [TCU_TERMS*TCU_DRL_EXP_W-1:0]      raw_exp_y,
  input  logic [TCU_TCK*TCU_DRL_DIFF_W-1:0]       exp_diff_f8,
  input  logic [TCU_DRL_TAG_W-1:0]                tag_in,
  output logic                                    valid_out,
  input  logic                                    ready_out,
  output logic [TCU_DRL_EXP_W-1:0]                max_exp,
  output logic [TCU_TERMS*TCU_DRL_SHIFT_W-1:0]    shift_amt,
  output logic                                    all_zero,
  output logic [TCU_TCK*TCU_DRL_DIFF_W-1:0]       exp_diff_out,
  output logic [TCU_DRL_TAG_W-1:0]                tag_out
);

  tcu_drl_exp_beat_t in_beat;
  tcu_drl_exp_t      in_max;

  logic              s1_vld;
  tcu_drl_exp_beat_t s1_beat;
  tcu_drl_exp_t      s1_max;
  logic              s1_all_zero;

  logic                                   s2_vld;
  tcu_drl_exp_t                           s2_max;
  logic                                   s2_all_zero;
  logic [TCU_TCK:0][TCU_DRL_SHIFT_W-1:0]  s2_shift;
  logic [TCU_TCK:0][TCU_DRL_SHIFT_W-1:0]  shift_d;
  logic [TCU_TCK-1:0][TCU_DRL_DIFF_W-1:0] s2_diff;
  logic [TCU_DRL_TAG_W-1:0]               s2_tag;

  logic s1_load;
  logic s2_adv;

  assign in_beat.exp     = raw_exp_y;
  assign in_beat.diff_f8 = exp_diff_f8;
  assign in_beat.tag     = tag_in;

  // A stage may take a new beat when it is empty or its content moves on this cycle.
  assign s2_adv   = ~s2_vld | ready_out;
  assign ready_in = ~s1_vld | s2_adv;
  assign s1_load  = valid_in & ready_in;

  vx_tcu_drl_max_exp_max_tree #(
    .N_IN (TCU_TERMS),
    .W    (TCU_DRL_EXP_W)
  ) u_max_tree (
    .in_vals (in_beat.exp),
    .max_val (in_max)
  );

  // NOTE: the datapath registers are reset too, because the outputs they drive
  // must read as zero while reset is asserted, not only the valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld      <= 1'b0;
      s1_beat     <= '0;
      s1_max      <= '0;
      s1_all_zero <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (ready_in)
        s1_vld <= valid_in;
      if (s1_load) begin
        s1_beat     <= in_beat;
        s1_max      <= in_max;
        s1_all_zero <= (in_max == '0);
      end
    end
  end

  always_comb begin
    shift_d = '0;
    for (int i = 0; i <= TCU_TCK; i++)
      shift_d[i] = drl_shift(s1_max, s1_beat.exp[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld      <= 1'b0;
      s2_max      <= '0;
      s2_all_zero <= 1'b0;
      s2_shift    <= '0;
      s2_diff     <= '0;
      s2_tag      <= '0;
    end else begin
      if (s2_adv)
        s2_vld <= s1_vld;
      if (s2_adv && s1_vld) begin
        s2_max      <= s1_max;
        s2_all_zero <= s1_all_zero;
        s2_shift    <= shift_d;
        s2_diff     <= s1_beat.diff_f8;
        s2_tag      <= s1_beat.tag;
      end
    end
  end

  assign valid_out    = s2_vld;
  assign max_exp      = s2_max;
  assign all_zero     = s2_all_zero;
  assign shift_amt    = s2_shift;
  assign exp_diff_out = s2_diff;
  assign tag_out      = s2_tag;

endmodule
